// File: rtl/mem2axis_pkg.sv
// mem2axis_pkg: shared types and constants for the mem2axis frame transmitter.
//   state_t    - frame sequencer states
//   SKID_DEPTH - output buffer depth; also the bound on reads outstanding
//   len_ok()   - frame length legality check (1..depth)
package mem2axis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int unsigned SKID_DEPTH = 2;

  function automatic logic len_ok(input int unsigned len, input int unsigned depth);
    return (len >= 1) && (len <= depth);
  endfunction

endpackage

// File: rtl/mem2axis_if.sv
// axis_if: minimal valid/ready stream bundle.
//   data[DW] - beat payload
//   vld      - beat valid (source)
//   last     - final beat of a frame (source)
//   rdy      - sink ready
// Modports: master/out (source side), slave (sink side).
interface axis_if #(
  parameter int unsigned DW = 32
) ();
  logic [DW-1:0] data;
  logic          vld;
  logic          last;
  logic          rdy;

  modport master (output data, output vld, output last, input rdy);
  modport out    (output data, output vld, output last, input rdy);
  modport slave  (input data, input vld, input last, output rdy);
endinterface

// File: rtl/mem2axis_skid.sv
// mem2axis_skid: 2-entry valid/ready buffer carrying DW data + last flag.
//   clk, rst  - clock, async active-high reset
//   push_i    - write data_i/last_i (caller guarantees space)
//   pop_i     - head consumed this cycle (caller guarantees vld_o)
//   flush_i   - discard all contents, including a same-cycle push
//   vld_o     - buffer non-empty; data_o/last_o show the head entry
//   occ_o     - current occupancy (0..2), used for read-issue gating
module mem2axis_skid
  import mem2axis_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] d0_q, d1_q;
  logic          l0_q, l1_q;
  logic [1:0]    occ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_q  <= '0;
      d1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
      occ_q <= '0;
    end else if (flush_i) begin
      occ_q <= '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) begin
            d0_q <= data_i;
            l0_q <= last_i;
          end else begin
            d1_q <= data_i;
            l1_q <= last_i;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          d0_q  <= d1_q;
          l0_q  <= l1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; new entry goes behind whatever remains.
          if (occ_q == 2'd1) begin
            d0_q <= data_i;
            l0_q <= last_i;
          end else begin
            d0_q <= d1_q;
            l0_q <= l1_q;
            d1_q <= data_i;
            l1_q <= last_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign vld_o  = (occ_q != 2'd0);
  assign data_o = d0_q;
  assign last_o = l0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/mem2axis.sv
// mem2axis: frame transmitter. A DEPTH-word frame buffer loaded through a
// simple write port is streamed out as words 0..len-1 on start, with last on
// the final beat. One beat/cycle under continuous rdy; any backpressure.
//   clk, rst              - clock, async active-high reset
//   wr_en/wr_addr/wr_data - buffer write port (addr >= DEPTH ignored)
//   start/frame_len       - frame request, legal lengths 1..DEPTH
//   busy                  - frame in progress
//   done                  - one-cycle pulse after the final beat handshake
//   stream_out            - axis_if source port
//   loop                  - only with MEM2AXIS_LOOP_EN: restart the frame at
//                           the final handshake instead of finishing
module mem2axis
  import mem2axis_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              start,
  input  logic [ADDR_W:0]   frame_len,
`ifdef MEM2AXIS_LOOP_EN
  input  logic              loop,
`endif
  output logic              busy,
  output logic              done,
  axis_if.out               stream_out
);

  localparam int unsigned LW = ADDR_W + 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d, cnt_nx;
  logic          done_q, done_d;
  logic          rd_vld_q, rd_last_q;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic          issue, flush, room, pop, last_pop, cnt_is_last, wr_ok, loop_on;
  logic          skid_vld, skid_last;
  logic [DW-1:0] skid_data;
  logic [1:0]    skid_occ;

`ifdef MEM2AXIS_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  assign wr_ok       = wr_en && ({1'b0, wr_addr} < LW'(DEPTH));
  assign pop         = skid_vld && stream_out.rdy;
  assign last_pop    = pop && skid_last;
  assign cnt_is_last = (cnt_q == (len_q - LW'(1)));
  // Count the beat leaving this cycle so a full pipeline still issues every
  // cycle; occupancy plus reads in flight never exceeds the buffer depth.
  assign room = (({1'b0, skid_occ} + {2'b0, rd_vld_q} - {2'b0, pop}) < 3'(SKID_DEPTH));

  // Block RAM: registered read, read-first on same-address collision, no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr[AW-1:0]] <= wr_data;
    if (issue) rd_data_q <= mem_q[cnt_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rd_vld_q  <= issue;
      rd_last_q <= issue && cnt_is_last;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    cnt_nx  = cnt_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && len_ok(32'(frame_len), DEPTH)) begin
          len_d   = frame_len;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (room) begin
          issue = 1'b1;
          if (cnt_is_last) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
      end
      FLUSH: begin
        // In FLUSH cnt_q counts speculative reads of the next pass (loop only);
        // anything queued behind the final beat belongs to that next pass.
        if (loop_on && (cnt_q != len_q) && room) begin
          issue  = 1'b1;
          cnt_nx = cnt_q + LW'(1);
        end
        cnt_d = cnt_nx;
        if (last_pop) begin
          if (loop_on) begin
            if (cnt_nx == len_q) begin
              cnt_d   = '0;
              state_d = FLUSH;
            end else begin
              state_d = RUN;
            end
          end else begin
            issue   = 1'b0;
            flush   = 1'b1;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mem2axis_skid #(
    .DW (DW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_vld_q),
    .data_i  (rd_data_q),
    .last_i  (rd_last_q),
    .pop_i   (pop),
    .flush_i (flush),
    .vld_o   (skid_vld),
    .data_o  (skid_data),
    .last_o  (skid_last),
    .occ_o   (skid_occ)
  );

  assign stream_out.vld  = skid_vld;
  assign stream_out.data = skid_data;
  assign stream_out.last = skid_last;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;

endmodule

// File: tb/tb_mem2axis.sv
module tb_mem2axis;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic [10:0] frame_len = '0;
  logic        busy, done;
`ifdef MEM2AXIS_LOOP_EN
  logic        loop = 1'b0;
`endif

  axis_if #(.DW(32)) sif ();

  mem2axis #(.DW(32), .ADDR_W(10), .DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .frame_len  (frame_len),
`ifdef MEM2AXIS_LOOP_EN
    .loop       (loop),
`endif
    .busy       (busy),
    .done       (done),
    .stream_out (sif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        done_after;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   beats_seen = 0;
  logic done_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [31:0] d, input logic l, input logic dn);
    exp_t e;
    e.data = d;
    e.last = l;
    e.done_after = dn;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    tick();
    tick();
  endtask

  // Monitor: every beat on the bus is checked against the queue head, so a
  // stalled beat is re-checked each cycle it is held.
  always @(negedge clk) begin
    chk("done", 32'(done), 32'(done_pend));
    done_pend = 1'b0;
    if (sif.vld) begin
      if (sb.size() == 0) begin
        chk("extra_beat_vld", 32'(sif.vld), 32'd0);
      end else begin
        chk("data", sif.data, sb[0].data);
        chk("last", 32'(sif.last), 32'(sb[0].last));
        if (sif.rdy) begin
          done_pend = sb[0].done_after;
          void'(sb.pop_front());
          beats_seen++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps;
    int base;
    int n;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    sif.rdy = 1'b0;
    tick();
    tick();
    chk("rst_vld", 32'(sif.vld), 32'd0);
    chk("rst_last", 32'(sif.last), 32'd0);
    chk("rst_data", sif.data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_addr = 10'(i);
      wr_data = 32'(32'hA0 + i);
      tick();
    end
    wr_en = 1'b0;

    // Full frame, rdy held high.
    sif.rdy = 1'b1;
    for (int i = 0; i < 16; i++) exp_push(32'(32'hA0 + i), i == 15, i == 15);
    start = 1'b1;
    frame_len = 11'd16;
    tick();
    start = 1'b0;
    chk("busy_e0", 32'(busy), 32'd1);
    chk("vld_e0", 32'(sif.vld), 32'd0);
    tick();
    chk("vld_e1", 32'(sif.vld), 32'd0);
    tick();
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      if (!sif.vld) gaps++;
      tick();
    end
    chk("b2b_gaps", 32'(gaps), 32'd0);
    drain(50);
    chk("busy_end1", 32'(busy), 32'd0);

    // len=5 under backpressure.
    for (int i = 0; i < 5; i++) exp_push(32'(32'hA0 + i), i == 4, i == 4);
    start = 1'b1;
    frame_len = 11'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      sif.rdy = (n < 4) ? pat[n] : 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    sif.rdy = 1'b1;
    drain(20);

    // len=1, out-of-range write, then illegal lengths.
    wr_en = 1'b1;
    wr_addr = 10'd16;
    wr_data = 32'h0000_0BAD;
    tick();
    wr_en = 1'b0;
    exp_push(32'hA0, 1'b1, 1'b1);
    start = 1'b1;
    frame_len = 11'd1;
    tick();
    start = 1'b0;
    drain(20);
    start = 1'b1;
    frame_len = 11'd0;
    tick();
    start = 1'b0;
    chk("len0_busy", 32'(busy), 32'd0);
    tick();
    tick();
    chk("len0_busy_late", 32'(busy), 32'd0);
    start = 1'b1;
    frame_len = 11'd17;
    tick();
    start = 1'b0;
    chk("len17_busy", 32'(busy), 32'd0);
    tick();
    tick();
    chk("len17_busy_late", 32'(busy), 32'd0);
    chk("len17_vld", 32'(sif.vld), 32'd0);

    // Reset mid-frame, then restart from preserved memory.
    for (int i = 0; i < 16; i++) exp_push(32'(32'hA0 + i), i == 15, i == 15);
    base = beats_seen;
    start = 1'b1;
    frame_len = 11'd16;
    tick();
    start = 1'b0;
    n = 0;
    while (beats_seen < base + 3 && n < 100) begin
      tick();
      n++;
    end
    chk("beats_before_rst", 32'(beats_seen - base), 32'd3);
    rst = 1'b1;
    #1;
    chk("midrst_vld", 32'(sif.vld), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) exp_push(32'(32'hA0 + i), i == 3, i == 3);
    start = 1'b1;
    frame_len = 11'd4;
    tick();
    start = 1'b0;
    drain(30);

    // Start while busy is ignored; a write ahead of the read pointer shows up.
    for (int i = 0; i < 16; i++)
      exp_push((i == 10) ? 32'h55 : 32'(32'hA0 + i), i == 15, i == 15);
    start = 1'b1;
    frame_len = 11'd16;
    tick();
    wr_en = 1'b1;
    wr_addr = 10'd10;
    wr_data = 32'h55;
    frame_len = 11'd4;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    chk("busy_ignore", 32'(busy), 32'd1);
    drain(60);
    tick();
    chk("busy_end5", 32'(busy), 32'd0);

`ifdef MEM2AXIS_LOOP_EN
    // Looping frame: three passes of len=3 back-to-back, loop dropped in the third.
    loop = 1'b1;
    for (int i = 0; i < 9; i++) exp_push(32'(32'hA0 + (i % 3)), (i % 3) == 2, i == 8);
    start = 1'b1;
    frame_len = 11'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    gaps = 0;
    for (int i = 0; i < 9; i++) begin
      if (!sif.vld) gaps++;
      if (i == 7) loop = 1'b0;
      tick();
    end
    chk("loop_gaps", 32'(gaps), 32'd0);
    drain(20);
    chk("loop_busy_end", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem2axis.md
Name: mem2axis

Overview:
- Frame transmitter, the read-side counterpart to the stream-to-memory capture path.
- Holds a DEPTH-entry block-RAM frame buffer, loaded through a simple write port.
- On a start command, streams words 0..len-1 out over an axis_if master port; asserts last on the final beat.
- Sustains 1 beat/cycle under continuous rdy; tolerates arbitrary backpressure with no data loss.

Parameters:
- DW, 32, stream and memory data width.
- ADDR_W, 10, memory address width; must be >= $clog2(DEPTH).
- DEPTH, 16, number of memory words (max frame length).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  memory write strobe.
- wr_addr  in  ADDR_W  write address; values >= DEPTH are ignored (no write).
- wr_data  in  DW  write data.
- start  in  1  frame request, sampled on posedge.
- frame_len  in  ADDR_W+1  beats in frame, 1..DEPTH; sampled with start.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final beat handshake.
- stream_out  axis_if.out  -  data[DW], vld, last driven; rdy received.

Behaviour:
- Reset (async assert, sync release):
  - vld=0, last=0, data=0, busy=0, done=0.
  - FSM=IDLE; read pointer, beat counter and skid buffer cleared.
  - Memory contents are not reset and survive rst.
- Reset mid-frame: vld drops immediately, frame discarded, no done.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: start=1 with 1<=frame_len<=DEPTH latches len; raddr=0; busy=1 next edge; go RUN.
  - IDLE, illegal length: start with frame_len=0 or >DEPTH is ignored, with no busy and no done.
  - RUN: issue a read whenever skid occupancy + reads in flight < 2, raddr++. After len reads issued, go FLUSH.
  - FLUSH: wait until the final beat (index len-1) handshakes. Next cycle: done=1, busy=0, go IDLE.
  - start while busy=1 is ignored.
- Memory timing:
  - Read latency is 1 cycle (registered BRAM output).
  - Same-cycle write and read to the same address returns the OLD data (read-first).
  - Writes are allowed at any time; a write to an address not yet read in the current frame is visible in that frame.
- Output path:
  - 2-entry skid buffer absorbs the in-flight read under backpressure.
  - stream_out.vld = skid non-empty.
  - data and last are held stable while vld && !rdy.
  - vld never deasserts without a handshake.
- last=1 only on beat len-1; len=1 gives a single beat with last=1.
- Latency: start sampled at edge E0 gives the first vld=1 after edge E2. With rdy held high, beats are back-to-back, and done is high in the cycle after the last handshake.
- rdy low forever: at most 2 reads are outstanding, and the pointer stalls without overrun.

Optional Feature:
- Macro MEM2AXIS_LOOP_EN.
- Defined:
  - Adds input port loop (1 bit).
  - If loop=1 when the final beat handshakes, the frame restarts at address 0 with no bubble (reads prefetched across the boundary).
  - No done pulse on a restart; busy stays 1.
  - loop=0 at the final handshake ends the frame normally.
- Undefined: port absent; exactly one frame per start.

Decomposition:
- mem2axis_pkg:
  - state_t enum {IDLE, RUN, FLUSH}.
  - SKID_DEPTH=2 constant.
  - Length-legality helper function.
- Sub-module mem2axis_skid: 2-entry valid/ready buffer with DW data + 1-bit last; occupancy output used for read-issue gating.

Test Plan:
- Write 0xA0..0xAF to addr 0..15; start, len=16, rdy=1 -> 16 consecutive beats 0xA0..0xAF; last only on 0xAF; first vld 2 cycles after start; done 1 cycle after the last beat.
- Same data, len=5, rdy toggling 1,0,0,1 random -> beats 0xA0..0xA4 in order, no duplicates or drops; data stable while stalled; last on 0xA4.
- len=1 -> single beat 0xA0 with last=1, done pulse; then len=0 and len=17 -> ignored, busy stays 0.
- Assert rst for 1 cycle after beat 3 of a len=16 frame -> vld=0 immediately, no done; restart with len=4 -> 0xA0..0xA3 (memory preserved).
- Pulse start during busy, and write addr 10 = 0x55 before it is read in a len=16 frame -> second start ignored; beat 10 = 0x55.
- MEM2AXIS_LOOP_EN, loop=1, len=3 -> A0,A1,A2,A0,A1,... with no gaps; drop loop -> frame ends after A2, done pulses.
